// File: rtl/pad_cfg_pkg.sv
// Shared constants and state encoding for the pad configuration serial transmitter.
// The chain-reset sequence length applies only when PAD_CFG_CHAIN_RESET_EN is defined.
package pad_cfg_pkg;

    localparam int NUM_PADS_DEF  = 19;
    localparam int CFG_WIDTH_DEF = 13;
    localparam int CLK_DIV_DEF   = 2;
    localparam int CRST_LEN      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SHIFT,
        ST_LOAD,
        ST_FIN,
        ST_CRST
    } state_e;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/pad_cfg_bit_timer.sv
// Serial-clock divider: each bit is a low half then a high half of CLK_DIV cycles.
// phase_o is the phase for the coming cycle so the caller can register it alongside its state.
module pad_cfg_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic en_i,
    output logic phase_o,
    output logic bit_end_o
);
    import pad_cfg_pkg::*;

    localparam int CNT_W = clog2_min1(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             half_end;

    assign half_end = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Disabled timer sits at the start of a low half, so every enable begins a fresh bit.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en_i) begin
            if (half_end) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o   = phase_d;
    assign bit_end_o = en_i & phase_q & half_end;

endmodule

// File: rtl/pad_cfg_serial_tx.sv
// Shifts per-pad config words (farthest pad first, MSB first) into the pad control chain.
// Define PAD_CFG_CHAIN_RESET_EN to pulse serial_resetn low before each transfer.
module pad_cfg_serial_tx
    import pad_cfg_pkg::*;
#(
    parameter  int NUM_PADS  = NUM_PADS_DEF,
    parameter  int CFG_WIDTH = CFG_WIDTH_DEF,
    parameter  int CLK_DIV   = CLK_DIV_DEF,
    localparam int IDX_W     = clog2_min1(NUM_PADS)
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 start,
    output logic [IDX_W-1:0]     cfg_rd_idx,
    input  logic [CFG_WIDTH-1:0] cfg_rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 serial_clock,
    output logic                 serial_data,
    output logic                 serial_load,
    output logic                 serial_resetn
);

    localparam int CRST_BITS = CRST_LEN / 2;
    localparam int BW_SH     = clog2_min1(CFG_WIDTH);
    localparam int BW_CR     = clog2_min1(CRST_BITS);
    localparam int BIT_W     = (BW_SH > BW_CR) ? BW_SH : BW_CR;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     pad_idx_q, pad_idx_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CFG_WIDTH-1:0] shreg_q, shreg_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sclk_q, sclk_d;
    logic sdata_q, sdata_d;
    logic load_q, load_d;
    logic srn_q, srn_d;

    logic tmr_en, tmr_phase, bit_end;

    assign tmr_en = (state_q == ST_SHIFT) || (state_q == ST_LOAD) || (state_q == ST_CRST);

    pad_cfg_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clock     (clock),
        .resetb    (resetb),
        .en_i      (tmr_en),
        .phase_o   (tmr_phase),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        pad_idx_d = pad_idx_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef PAD_CFG_CHAIN_RESET_EN
                    state_d = ST_CRST;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                shreg_d = cfg_rd_data;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == BIT_W'(CFG_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        // Index 0 is terminal; it never wraps back to the top.
                        if (pad_idx_q != '0) begin
                            pad_idx_d = pad_idx_q - 1'b1;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d   = ST_LOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bit_end) begin
                    pad_idx_d = IDX_W'(NUM_PADS - 1);
                    state_d   = ST_FIN;
                end
            end
            ST_FIN:     state_d = ST_IDLE;
`ifdef PAD_CFG_CHAIN_RESET_EN
            ST_CRST: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(CRST_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d  = (state_d == ST_FIN);
        sclk_d  = (state_d == ST_SHIFT) && tmr_phase;
        sdata_d = (state_d == ST_SHIFT) && shreg_d[CFG_WIDTH-1];
        load_d  = (state_d == ST_LOAD);
`ifdef PAD_CFG_CHAIN_RESET_EN
        srn_d   = (state_d != ST_CRST);
`else
        srn_d   = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            pad_idx_q <= IDX_W'(NUM_PADS - 1);
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            load_q    <= 1'b0;
            srn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pad_idx_q <= pad_idx_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            load_q    <= load_d;
            srn_q     <= srn_d;
        end
    end

    assign cfg_rd_idx    = pad_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign serial_clock  = sclk_q;
    assign serial_data   = sdata_q;
    assign serial_load   = load_q;
    assign serial_resetn = srn_q;

endmodule

// File: tb/tb_pad_cfg_serial_tx.sv
// Directed/randomized bench for pad_cfg_serial_tx with a bitstream and timing reference model.
module tb_pad_cfg_serial_tx;

    localparam int NP   = 3;
    localparam int CW   = 5;
    localparam int CD   = 2;
    localparam int IW   = $clog2(NP);
`ifdef PAD_CFG_CHAIN_RESET_EN
    localparam int CRST_CYC = 8 * CD;
`else
    localparam int CRST_CYC = 0;
`endif
    localparam int TOTAL = NP * (2 + 2 * CW * CD) + 2 * CD + CRST_CYC;

    logic          clock = 1'b0;
    logic          resetb;
    logic          start;
    logic [IW-1:0] cfg_rd_idx;
    logic [CW-1:0] cfg_rd_data;
    logic          busy, done, serial_clock, serial_data, serial_load, serial_resetn;

    logic [CW-1:0] mem [NP];

    int checks = 0;
    int errors = 0;

    pad_cfg_serial_tx #(
        .NUM_PADS  (NP),
        .CFG_WIDTH (CW),
        .CLK_DIV   (CD)
    ) dut (
        .clock         (clock),
        .resetb        (resetb),
        .start         (start),
        .cfg_rd_idx    (cfg_rd_idx),
        .cfg_rd_data   (cfg_rd_data),
        .busy          (busy),
        .done          (done),
        .serial_clock  (serial_clock),
        .serial_data   (serial_data),
        .serial_load   (serial_load),
        .serial_resetn (serial_resetn)
    );

    always #5 clock = ~clock;

    // Register file: data for an index is available one cycle after the index is presented.
    always @(posedge clock) cfg_rd_data <= mem[cfg_rd_idx];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"},   64'(cfg_rd_idx), 64'(NP - 1));
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_sclk"},  64'(serial_clock), 64'd0);
        check({tag, "_sdata"}, 64'(serial_data), 64'd0);
        check({tag, "_load"},  64'(serial_load), 64'd0);
    endtask

    task automatic randomize_mem();
        for (int p = 0; p < NP; p++) mem[p] = CW'($urandom);
    endtask

    // Runs one transfer from a start pulse and compares the observed chain traffic with
    // the bitstream and cycle counts expected from the pad words.
    task automatic run_transfer(input int id, input bit extra_starts);
        logic [63:0] exp_bits, got_bits;
        int busy_cnt, busy_first, done_cnt, done_at, load_cnt, load_last, rises, both;
        int hi_run, lo_run, hi_bad, lo_bad, data_bad, srn_low;
        logic prev_clk, prev_data, c;

        exp_bits = '0;
        for (int p = NP - 1; p >= 0; p--)
            for (int b = CW - 1; b >= 0; b--)
                exp_bits = {exp_bits[62:0], mem[p][b]};

        got_bits = '0;
        busy_cnt = 0; busy_first = -1; done_cnt = 0; done_at = -1; load_cnt = 0; load_last = -1;
        rises = 0; both = 0; hi_run = 0; lo_run = 0; hi_bad = 0; lo_bad = 0; data_bad = 0;
        srn_low = 0; prev_clk = 1'b0; prev_data = 1'b0;

        @(negedge clock);
        start = 1'b1;
        for (int n = 1; n <= TOTAL + 6; n++) begin
            @(negedge clock);
            start = extra_starts && (n == 5 || n == 10 || n == TOTAL + 1);
            c = serial_clock;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = n;
            end
            if (done) begin done_cnt++; done_at = n; end
            if (serial_load) begin load_cnt++; load_last = n; end
            if (serial_load && c) both++;
            if (!serial_resetn) srn_low++;
            if (c && !prev_clk) begin
                if ((rises % CW) != 0 && lo_run != CD) lo_bad++;
                rises++;
                got_bits = {got_bits[62:0], serial_data};
                hi_run = 1;
            end else if (c) begin
                hi_run++;
                if (serial_data !== prev_data) data_bad++;
            end
            if (!c && prev_clk) begin
                if (hi_run != CD) hi_bad++;
                lo_run = 1;
            end else if (!c) begin
                lo_run++;
            end
            prev_clk = c;
            prev_data = serial_data;
        end
        start = 1'b0;

        check("rises",      64'(rises), 64'(NP * CW));
        check("bitstream",  got_bits, exp_bits);
        check("busy_cnt",   64'(busy_cnt), 64'(TOTAL));
        check("busy_first", 64'(busy_first), 64'd1);
        check("done_cnt",   64'(done_cnt), 64'd1);
        check("done_at",    64'(done_at), 64'(TOTAL + 1));
        check("load_cnt",   64'(load_cnt), 64'(2 * CD));
        check("load_last",  64'(load_last), 64'(TOTAL));
        check("load_clk",   64'(both), 64'd0);
        check("hi_phase",   64'(hi_bad), 64'd0);
        check("lo_phase",   64'(lo_bad), 64'd0);
        check("data_hold",  64'(data_bad), 64'd0);
        check("srn_low",    64'(srn_low), 64'(CRST_CYC));
        check("idle_idx",   64'(cfg_rd_idx), 64'(NP - 1));
        $display("transfer %0d: extra_starts=%0d bits=%0h rises=%0d busy=%0d done_at=%0d",
                 id, extra_starts, got_bits, rises, busy_cnt, done_at);
    endtask

    initial begin
        resetb = 1'b0;
        start  = 1'b0;
        for (int p = 0; p < NP; p++) mem[p] = '0;

        repeat (3) @(negedge clock);
        check_reset_outputs("in_reset");
        check("in_reset_srn", 64'(serial_resetn), 64'd0);

        resetb = 1'b1;
        repeat (10) @(negedge clock);
        check_reset_outputs("idle");
        check("idle_srn", 64'(serial_resetn), 64'd1);
        $display("idle: idx=%0d srn=%0b", cfg_rd_idx, serial_resetn);

        for (int t = 0; t < 4; t++) begin
            randomize_mem();
            run_transfer(t, 1'b0);
        end

        randomize_mem();
        run_transfer(4, 1'b1);

        // Asynchronous reset while the first bit (forced to 1) is on the line.
        randomize_mem();
        mem[NP-1][CW-1] = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (CRST_CYC + 3) @(negedge clock);
        check("pre_rst_busy",  64'(busy), 64'd1);
        check("pre_rst_sdata", 64'(serial_data), 64'd1);
        #1;
        resetb = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        check("async_rst_srn", 64'(serial_resetn), 64'd0);
        $display("async reset mid-shift: busy=%0b sdata=%0b srn=%0b", busy, serial_data, serial_resetn);
        @(negedge clock);
        resetb = 1'b1;
        #1;
        check("rel_srn_low", 64'(serial_resetn), 64'd0);
        @(negedge clock);
        check("rel_srn_high", 64'(serial_resetn), 64'd1);

        randomize_mem();
        run_transfer(5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
